// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/clear sequencer: button synchronizers, 1 Hz prescaler,
// and a BCD mm:ss counter that only advances while running.
module stopwatch_ctrl #(
    parameter int CLK_DIV = 50_000_000,
    parameter int MAX_MIN = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       btn_clear,
    output logic       start_o,
    output logic       pause_o,
    output logic       tick,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic       rollover,
    output logic [1:0] state
);

    localparam int              PW          = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]   TERM        = PW'(CLK_DIV - 1);
    localparam logic [7:0]      MAX_MIN_BCD = 8'(((MAX_MIN / 10) * 16) + (MAX_MIN % 10));

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        PAUSED = 2'b10
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic [7:0]    r_sec;
    logic [7:0]    r_min;
    logic          r_tick;
    logic          r_roll;

    // Button vectors are packed {clear, pause, start}; _p0/_p1 synchronize, _p2 is the edge history.
    logic [2:0]    r_btn_p0;
    logic [2:0]    r_btn_p1;
    logic [2:0]    r_btn_p2;
    logic [2:0]    w_evt;
    logic          w_clr;
    logic          w_pse;
    logic          w_sta;
    logic          w_term;

    assign w_evt  = r_btn_p1 & ~r_btn_p2;
    assign w_clr  = w_evt[2];
    assign w_pse  = w_evt[1];
    assign w_sta  = w_evt[0];
    assign w_term = (r_presc == TERM);

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_p0 <= '0;
            r_btn_p1 <= '0;
            r_btn_p2 <= '0;
            r_state  <= IDLE;
            r_presc  <= '0;
            r_sec    <= '0;
            r_min    <= '0;
            r_tick   <= 1'b0;
            r_roll   <= 1'b0;
        end else begin
            r_btn_p0 <= {btn_clear, btn_pause, btn_start};
            r_btn_p1 <= r_btn_p0;
            r_btn_p2 <= r_btn_p1;
            r_tick   <= 1'b0;
            r_roll   <= 1'b0;
            if (w_clr) begin
                r_state <= IDLE;
                r_presc <= '0;
                r_sec   <= '0;
                r_min   <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_sta)
                            r_state <= RUN;
                    end
                    RUN: begin
                        // A pause landing on terminal count still lets this tick through.
                        if (w_pse)
                            r_state <= PAUSED;
                        if (w_term) begin
                            r_presc <= '0;
                            r_tick  <= 1'b1;
                            if (r_sec == 8'h59) begin
                                r_sec <= 8'h00;
                                if (r_min == MAX_MIN_BCD) begin
                                    r_min  <= 8'h00;
                                    r_roll <= 1'b1;
                                end else begin
                                    r_min <= bcd_inc(r_min);
                                end
                            end else begin
                                r_sec <= bcd_inc(r_sec);
                            end
                        end else begin
                            r_presc <= r_presc + 1'b1;
                        end
                    end
                    PAUSED: begin
                        if (w_sta)
                            r_state <= RUN;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign start_o  = (r_state == RUN);
    assign pause_o  = (r_state == PAUSED);
    assign tick     = r_tick;
    assign rollover = r_roll;
    assign sec_bcd  = r_sec;
    assign min_bcd  = r_min;
    assign state    = r_state;

endmodule
